opc5_mem_arbiter: RTL and testbench
===================================

// Module: opc5_mem_arbiter
// PURPOSE
//  Shares the single-port, async-read program/data RAM between the opc5 CPU and a DMA/loader port.
//  CPU is stalled through a clock-enable (cpu_ce); DMA gets bounded bursts, then must yield to the CPU.
//  Sits between opc5 core, RAM and DMA master. All outputs decode from registered state (glitch-free).
// PARAMETERS
//  ADDR_W         16  address width, CPU and DMA
//  DATA_W         16  data width
//  DMA_BURST_MAX  8   max consecutive DMA-owned cycles before forced yield; 0 = unlimited
//  CPU_SLOT_MIN   2   CPU-owned cycles guaranteed after a forced yield (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  reset_b      in   1       reset, asynchronous, active-low
//  cpu_address  in   ADDR_W  CPU address
//  cpu_dataout  in   DATA_W  CPU write data
//  cpu_rnw      in   1       CPU read(1)/write(0)
//  cpu_datain   out  DATA_W  read data to CPU (= mem_rdata)
//  cpu_ce       out  1       CPU clock enable; 0 freezes all CPU state
//  dma_req      in   1       DMA request; addr/rnw/wdata stable while high
//  dma_rnw      in   1       DMA read(1)/write(0)
//  dma_addr     in   ADDR_W  DMA address
//  dma_wdata    in   DATA_W  DMA write data
//  dma_gnt      out  1       DMA owns RAM this cycle
//  dma_rdata    out  DATA_W  registered DMA read data
//  dma_rvalid   out  1       dma_rdata valid (1 cycle pulse)
//  mem_addr     out  ADDR_W  RAM address
//  mem_wdata    out  DATA_W  RAM write data
//  mem_we       out  1       RAM write enable, written at rising clk
//  mem_rdata    in   DATA_W  RAM async read data
// BEHAVIOUR
//  States: S_CPU, S_DMA, S_YIELD. cpu_ce = (state!=S_DMA); dma_gnt = (state==S_DMA).
//  Mux: S_DMA -> mem_* from dma_*, mem_we = dma_req & ~dma_rnw; else from cpu_*, mem_we = ~cpu_rnw.
//  DMA transfer = rising clk with dma_gnt=1 and dma_req=1; one word per cycle.
//  Grant latency: dma_req seen high in S_CPU at edge n -> dma_gnt=1 during cycle n+1. CPU runs cycle n.
//  S_CPU: dma_req -> S_DMA, burst_cnt<=1. Else stay.
//  S_DMA: ~dma_req -> S_CPU (dead cycle, no transfer, mem_we=0).
//    dma_req & DMA_BURST_MAX!=0 & burst_cnt==DMA_BURST_MAX -> S_YIELD, slot_cnt<=1.
//    else stay, burst_cnt<=burst_cnt+1 (saturating; no wrap when DMA_BURST_MAX=0).
//  S_YIELD: cpu_ce=1, dma_gnt=0, dma_req ignored. slot_cnt==CPU_SLOT_MIN -> S_DMA if dma_req
//    (burst_cnt<=1) else S_CPU; otherwise slot_cnt<=slot_cnt+1.
//  DMA read: transfer with dma_rnw=1 at edge k -> dma_rdata<=mem_rdata, dma_rvalid=1 for cycle k+1 only.
//  dma_rdata holds last value until next DMA read.
//  cpu_datain = mem_rdata at all times; CPU ignores it while cpu_ce=0.
//  CPU write issued in a cycle where cpu_ce=1 completes that cycle; never split or replayed.
//  Counter widths: $clog2(DMA_BURST_MAX+1), $clog2(CPU_SLOT_MIN+1), min 1 bit.
//  Reset (async): state=S_CPU, cpu_ce=1, dma_gnt=0, dma_rvalid=0, dma_rdata=0, counters=0.
//    mem_we forced 0 while reset_b=0. Reset mid-burst: grant drops immediately, no further DMA writes.
//  DMA dropping dma_req mid-burst is legal; re-request re-arbitrates from S_CPU with fresh burst count.
// TESTING
//  1 Idle DMA, CPU writes 0x1234 to 0x0040 -> mem_we=1 same cycle, cpu_ce stays 1, dma_gnt stays 0.
//  2 dma_req at edge 0, write 0xBEEF to 0x0100 -> gnt cycle 1, cpu_ce=0 cycle 1, RAM[0x0100]=0xBEEF.
//  3 dma_req held 20 cycles, defaults -> gnt 8, yield 2 (cpu_ce=1), gnt 8, yield 2, ...; no CPU starvation.
//  4 DMA read 0x0100 (holds 0xBEEF) -> dma_rvalid pulses one cycle after grant cycle, dma_rdata=0xBEEF.
//  5 reset_b low during 3rd burst write -> dma_gnt=0, cpu_ce=1, mem_we=0 immediately; state S_CPU.
//  6 DMA_BURST_MAX=0, dma_req held 50 cycles -> dma_gnt held 50 cycles, no yield, burst_cnt no wrap.

Source files
------------

// File: rtl/opc5_mem_arbiter.sv
// Arbitrates the single-port async-read RAM between the opc5 CPU (stalled via cpu_ce)
// and a DMA/loader port that gets bounded bursts followed by a guaranteed CPU slot.
module opc5_mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int DMA_BURST_MAX = 8,
    parameter int CPU_SLOT_MIN  = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataout,
    input  logic              cpu_rnw,
    output logic [DATA_W-1:0] cpu_datain,
    output logic              cpu_ce,
    input  logic              dma_req,
    input  logic              dma_rnw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);

    localparam int BW = (DMA_BURST_MAX < 1) ? 1 : $clog2(DMA_BURST_MAX + 1);
    localparam int SW = (CPU_SLOT_MIN < 1) ? 1 : $clog2(CPU_SLOT_MIN + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(DMA_BURST_MAX);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);
    localparam logic [SW-1:0] SLOT_LIMIT  = SW'(CPU_SLOT_MIN);
    localparam logic [SW-1:0] SLOT_ONE    = SW'(1);

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_DMA   = 2'd1,
        S_YIELD = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   burst_cnt, burst_nx;
    logic [SW-1:0]   slot_cnt, slot_nx;
    logic            dma_xfer;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= S_CPU;
            burst_cnt <= '0;
            slot_cnt  <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
            slot_cnt  <= slot_nx;
        end
    end

    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        slot_nx  = slot_cnt;
        case (state)
            S_CPU: begin
                if (dma_req) begin
                    state_nx = S_DMA;
                    burst_nx = BURST_ONE;
                end
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_nx = S_CPU;
                end else if ((DMA_BURST_MAX != 0) && (burst_cnt == BURST_LIMIT)) begin
                    state_nx = S_YIELD;
                    slot_nx  = SLOT_ONE;
                end else if (burst_cnt != {BW{1'b1}}) begin
                    // Saturate so an unlimited burst never wraps back to a small count.
                    burst_nx = burst_cnt + BURST_ONE;
                end
            end
            S_YIELD: begin
                if (slot_cnt == SLOT_LIMIT) begin
                    if (dma_req) begin
                        state_nx = S_DMA;
                        burst_nx = BURST_ONE;
                    end else begin
                        state_nx = S_CPU;
                    end
                end else begin
                    slot_nx = slot_cnt + SLOT_ONE;
                end
            end
            default: state_nx = S_CPU;
        endcase
    end

    // Handshake: dma_req is the valid and dma_gnt the ready; one word moves on every
    // rising clk where both are high, and the DMA must hold addr/rnw/wdata until then.
    assign dma_gnt    = (state == S_DMA);
    assign cpu_ce     = !dma_gnt;
    assign dma_xfer   = dma_gnt & dma_req;
    assign state_dbg  = state;
    assign cpu_datain = mem_rdata;
    assign mem_addr   = dma_gnt ? dma_addr : cpu_address;
    assign mem_wdata  = dma_gnt ? dma_wdata : cpu_dataout;
    assign mem_we     = reset_b & (dma_gnt ? (dma_req & ~dma_rnw) : ~cpu_rnw);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_xfer & dma_rnw;
            if (dma_xfer && dma_rnw) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// Bench for opc5_mem_arbiter: directed cases plus randomized DMA episodes checked
// against a burst/yield timeline model and a reference memory.
module tb_opc5_mem_arbiter;

    localparam int BURST = 8;
    localparam int SLOT  = 2;

    logic        clk;
    logic        reset_b;
    logic        ram_init;
    logic [15:0] cpu_address, cpu_dataout, cpu_datain, cpu_datain_u;
    logic        cpu_rnw, cpu_ce, cpu_ce_u;
    logic        dma_req, dma_req_u, dma_rnw;
    logic [15:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_gnt_u, dma_rvalid, dma_rvalid_u;
    logic [15:0] dma_rdata, dma_rdata_u;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem_addr_u, mem_wdata_u, mem_rdata_u;
    logic        mem_we, mem_we_u;
    logic [1:0]  state_dbg, state_dbg_u;

    logic [15:0] ram   [0:1023];
    logic [15:0] ram_u [0:255];

    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_rdata;
    logic        exp_rvalid;
    int          n_cmp;
    int          n_bad;

    opc5_mem_arbiter dut (
        .clk(clk), .reset_b(reset_b),
        .cpu_address(cpu_address), .cpu_dataout(cpu_dataout), .cpu_rnw(cpu_rnw),
        .cpu_datain(cpu_datain), .cpu_ce(cpu_ce),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .state_dbg(state_dbg)
    );

    opc5_mem_arbiter #(.DMA_BURST_MAX(0)) dut_u (
        .clk(clk), .reset_b(reset_b),
        .cpu_address(cpu_address), .cpu_dataout(cpu_dataout), .cpu_rnw(cpu_rnw),
        .cpu_datain(cpu_datain_u), .cpu_ce(cpu_ce_u),
        .dma_req(dma_req_u), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt_u), .dma_rdata(dma_rdata_u), .dma_rvalid(dma_rvalid_u),
        .mem_addr(mem_addr_u), .mem_wdata(mem_wdata_u), .mem_we(mem_we_u),
        .mem_rdata(mem_rdata_u), .state_dbg(state_dbg_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAMs: async read, write on rising clk.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            for (int i = 0; i < 256; i++) ram_u[i] <= '0;
        end else begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            if (mem_we_u) ram_u[mem_addr_u[7:0]] <= mem_wdata_u;
        end
    end
    assign mem_rdata   = ram[mem_addr[9:0]];
    assign mem_rdata_u = ram_u[mem_addr_u[7:0]];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_cpu();
        cpu_address = 16'($urandom_range(0, 31));
        cpu_dataout = 16'($urandom);
        cpu_rnw     = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_dma();
        dma_rnw   = 1'($urandom_range(0, 1));
        dma_addr  = 16'($urandom_range(0, 31));
        dma_wdata = 16'($urandom);
    endtask

    // One clock cycle: inputs already driven; check mid-cycle, then apply the edge to the model.
    task automatic cycle(input logic exp_gnt);
        logic exp_we;
        logic nxt_rvalid;
        @(negedge clk);
        exp_we = exp_gnt ? (dma_req & ~dma_rnw) : ~cpu_rnw;
        chk("dma_gnt", dma_gnt, exp_gnt);
        chk("cpu_ce", cpu_ce, !exp_gnt);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_gnt ? dma_addr : cpu_address);
        chk("dma_rvalid", dma_rvalid, exp_rvalid);
        chk("dma_rdata", dma_rdata, exp_rdata);
        nxt_rvalid = exp_gnt & dma_req & dma_rnw;
        if (nxt_rvalid) exp_rdata = ref_rd(dma_addr);
        exp_rvalid = nxt_rvalid;
        if (exp_we) begin
            if (exp_gnt) ref_mem[dma_addr] = dma_wdata;
            else ref_mem[cpu_address] = cpu_dataout;
        end
        @(posedge clk);
        #1;
    endtask

    // DMA wants n words: one latency cycle, then n grant cycles with a SLOT-cycle CPU
    // window after every BURST words, a dead grant cycle if it ends mid-burst, then a gap.
    task automatic run_episode(input int n, input int gap);
        dma_req = 1'b1;
        rand_cpu();
        cycle(1'b0);
        for (int i = 1; i <= n; i++) begin
            rand_cpu();
            cycle(1'b1);
            if (i < n) rand_dma();
            if (i % BURST == 0) begin
                dma_req = (i < n);
                for (int s = 0; s < SLOT; s++) begin
                    rand_cpu();
                    cycle(1'b0);
                end
            end
        end
        dma_req = 1'b0;
        if (n % BURST != 0) begin
            rand_cpu();
            cycle(1'b1);
        end
        for (int g = 0; g < gap; g++) begin
            rand_cpu();
            cycle(1'b0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_rdata = '0;
        exp_rvalid = 1'b0;
        reset_b = 1'b0;
        ram_init = 1'b1;
        cpu_address = '0; cpu_dataout = '0; cpu_rnw = 1'b1;
        dma_req = 1'b0; dma_req_u = 1'b0; dma_rnw = 1'b1; dma_addr = '0; dma_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        ram_init = 1'b0;
        @(negedge clk);
        chk("rst_gnt", dma_gnt, 1'b0);
        chk("rst_ce", cpu_ce, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_rvalid", dma_rvalid, 1'b0);
        chk("rst_rdata", dma_rdata, 16'h0000);
        chk("rst_state", state_dbg, 2'd0);
        chk("rst_u_gnt", dma_gnt_u, 1'b0);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        // Idle DMA, CPU write
        cpu_address = 16'h0040; cpu_dataout = 16'h1234; cpu_rnw = 1'b0;
        cycle(1'b0);
        cpu_rnw = 1'b1;
        chk("t1_ram", ram[10'h040], 16'h1234);

        // DMA write 0xBEEF to 0x0100
        dma_rnw = 1'b0; dma_addr = 16'h0100; dma_wdata = 16'hBEEF;
        run_episode(1, 1);
        chk("t2_ram", ram[10'h100], 16'hBEEF);

        // DMA read back 0x0100
        dma_rnw = 1'b1; dma_addr = 16'h0100;
        run_episode(1, 2);
        chk("t4_rdata", dma_rdata, 16'hBEEF);

        // Request held ~20 cycles: two full bursts with CPU windows
        rand_dma();
        run_episode(16, 2);

        // Randomized episodes
        for (int e = 0; e < 30; e++) begin
            rand_dma();
            run_episode($urandom_range(1, 20), $urandom_range(0, 3));
        end

        // Reset during the third write of a burst
        cpu_rnw = 1'b1;
        dma_req = 1'b1; dma_rnw = 1'b0; dma_addr = 16'h0200; dma_wdata = 16'h1111;
        cycle(1'b0);
        cycle(1'b1);
        dma_addr = 16'h0201; dma_wdata = 16'h2222;
        cycle(1'b1);
        dma_addr = 16'h0202; dma_wdata = 16'h3333;
        cpu_address = 16'h0203; cpu_dataout = 16'h7777; cpu_rnw = 1'b0;
        #1;
        chk("t5_pre_gnt", dma_gnt, 1'b1);
        reset_b = 1'b0;
        #1;
        chk("t5_gnt", dma_gnt, 1'b0);
        chk("t5_ce", cpu_ce, 1'b1);
        chk("t5_we", mem_we, 1'b0);
        chk("t5_state", state_dbg, 2'd0);
        @(posedge clk);
        #1;
        dma_req = 1'b0;
        cpu_rnw = 1'b1;
        exp_rdata = '0;
        exp_rvalid = 1'b0;
        #2;
        reset_b = 1'b1;
        chk("t5_ram_201", ram[10'h201], 16'h2222);
        chk("t5_ram_202", ram[10'h202], 16'h0000);
        chk("t5_ram_203", ram[10'h203], 16'h0000);
        rand_cpu();
        cycle(1'b0);

        // Unlimited bursts: grant held for the whole request
        cpu_rnw = 1'b1;
        dma_rnw = 1'b0;
        dma_req_u = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            dma_addr = 16'(100 + c);
            dma_wdata = 16'(c);
            @(negedge clk);
            if (c == 0) begin
                chk("t6_lat", dma_gnt_u, 1'b0);
            end else begin
                chk("t6_gnt", dma_gnt_u, 1'b1);
                chk("t6_ce", cpu_ce_u, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        dma_req_u = 1'b0;
        @(negedge clk);
        chk("t6_dead", dma_gnt_u, 1'b1);
        chk("t6_dead_we", mem_we_u, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_release", dma_gnt_u, 1'b0);
        chk("t6_ram_9", ram_u[109], 16'd9);
        chk("t6_ram_50", ram_u[150], 16'd50);

        // Final memory image against the reference
        for (int a = 0; a < 32; a++) begin
            chk("ram_img", ram[a], ref_rd(16'(a)));
        end
        chk("ram_img_100", ram[10'h100], ref_rd(16'h0100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
